dkong3_obj_scan: RTL and testbench

Per-line object scanner that reads the sprite object RAM filled by the sprite DMA, selects the objects that intersect the next scanline, and builds a double-buffered list of up to 16 entries for the sprite line renderer. Sits between the object RAM read port and the sprite renderer. Scans the line that will be drawn next while the renderer consumes the list from the previous scan.

---
 rtl/dkong3_obj_scan.sv | 258 +++++++++++++++++++++++++
 tb/tb_dkong3_obj_scan.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dkong3_obj_scan.sv
`default_nettype none
// ============================================================================
// Module   : dkong3_obj_scan
// Purpose  : Per-line sprite object scanner. Walks the object RAM written by
//            the sprite DMA, picks the objects that intersect the line about
//            to be drawn, and builds a double-buffered list (up to LIST_MAX
//            entries) for the sprite line renderer. The scan bank is filled
//            while the renderer reads the display bank from the last scan.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   I_CLK        in   1  core clock
//   I_RSTn       in   1  asynchronous active-low reset
//   I_H_START    in   1  line pulse: latch line, swap banks, start scan
//   I_VPOS       in   8  target line, sampled on I_H_START
//   I_DMA_BUSY   in   1  sprite DMA is writing object RAM
//   I_OBJ_DQ     in   8  object RAM read data (1 cycle after address)
//   O_OBJ_AB     out 10  object RAM read address
//   O_OBJ_RD     out  1  read strobe
//   I_LIST_IDX   in   4  renderer read index into the display bank
//   O_LIST_Y/CODE/ATTR/X out 8 each: display bank entry I_LIST_IDX
//   O_LIST_CNT   out  5  valid entries in the display bank
//   O_SCAN_DONE  out  1  scan finished, until the next I_H_START
//   O_OVERFLOW   out  1  display bank saw more than LIST_MAX hits
// Build option:
//   DKONG3_OBJSCAN_DMA_HOLD_EN  freeze the scan while I_DMA_BUSY is high and
//                              re-issue the pending read when it drops.
// ============================================================================
module dkong3_obj_scan #(
    parameter int OBJ_COUNT = 96,
    parameter int LIST_MAX  = 16,
    parameter int OBJ_H     = 16
) (
    input  logic       I_CLK,
    input  logic       I_RSTn,
    input  logic       I_H_START,
    input  logic [7:0] I_VPOS,
    input  logic       I_DMA_BUSY,
    input  logic [7:0] I_OBJ_DQ,
    output logic [9:0] O_OBJ_AB,
    output logic       O_OBJ_RD,
    input  logic [3:0] I_LIST_IDX,
    output logic [7:0] O_LIST_Y,
    output logic [7:0] O_LIST_CODE,
    output logic [7:0] O_LIST_ATTR,
    output logic [7:0] O_LIST_X,
    output logic [4:0] O_LIST_CNT,
    output logic       O_SCAN_DONE,
    output logic       O_OVERFLOW
);

    localparam logic [6:0] C_LAST_N   = 7'(OBJ_COUNT - 1);
    localparam logic [4:0] C_LIST_MAX = 5'(LIST_MAX);
    localparam logic [8:0] C_OBJ_H    = 9'(OBJ_H);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_CHK  = 3'd2,
        S_RD1  = 3'd3,
        S_RD2  = 3'd4,
        S_RD3  = 3'd5,
        S_CAP  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  n_q, n_d;
    logic [7:0]  vline_q, vline_d;
    logic [7:0]  y_q, y_d;
    logic [7:0]  code_q, code_d;
    logic [7:0]  attr_q, attr_d;
    logic        sel_q, sel_d;          // index of the bank being scanned into
    logic [4:0]  cnt_q [2];
    logic [1:0]  ovf_q;
    logic [31:0] bank_q [2][16];        // {Y, code, attr, X}

    logic        w_swap;
    logic        w_wr;
    logic        w_ovf_set;
    logic        w_scan;
    logic        w_disp;
    logic [7:0]  w_d;
    logic        w_hit;
    logic        w_freeze;
    logic        w_reissue;
    logic        w_busy_gate;
    logic        w_data_state;
    logic        w_addr_state;
    logic [1:0]  w_sub;

    assign w_scan = sel_q;
    assign w_disp = ~sel_q;

    // Line distance wraps mod 256 so objects straddling line 0 still hit.
    assign w_d   = vline_q - I_OBJ_DQ;
    assign w_hit = (I_OBJ_DQ != 8'h00) && ({1'b0, w_d} < C_OBJ_H);

    // States that consume I_OBJ_DQ addressed in the previous cycle.
    assign w_data_state = (state_q == S_CHK) || (state_q == S_RD2) ||
                          (state_q == S_RD3) || (state_q == S_CAP);
    assign w_addr_state = (state_q == S_ADDR) || (state_q == S_RD1) ||
                          (state_q == S_RD2)  || (state_q == S_RD3);

`ifdef DKONG3_OBJSCAN_DMA_HOLD_EN
    logic hold_q;

    // The cycle after a hold ends re-drives the address whose data the
    // frozen state still needs; the state itself waits one more cycle.
    assign w_reissue   = hold_q & ~I_DMA_BUSY & w_data_state;
    assign w_freeze    = I_DMA_BUSY | w_reissue;
    assign w_busy_gate = I_DMA_BUSY;

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= I_DMA_BUSY;
        end
    end
`else
    logic w_unused_busy;

    assign w_unused_busy = I_DMA_BUSY;
    assign w_reissue     = 1'b0;
    assign w_freeze      = 1'b0;
    assign w_busy_gate   = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        vline_d   = vline_q;
        y_d       = y_q;
        code_d    = code_q;
        attr_d    = attr_q;
        sel_d     = sel_q;
        w_swap    = 1'b0;
        w_wr      = 1'b0;
        w_ovf_set = 1'b0;

        if (I_H_START) begin
            w_swap  = 1'b1;
            sel_d   = ~sel_q;
            vline_d = I_VPOS;
            n_d     = 7'd0;
            state_d = S_ADDR;
        end else if (!w_freeze) begin
            case (state_q)
                S_ADDR: state_d = S_CHK;
                S_CHK: begin
                    if (w_hit) begin
                        if (cnt_q[w_scan] == C_LIST_MAX) begin
                            w_ovf_set = 1'b1;
                            state_d   = S_DONE;
                        end else begin
                            y_d     = I_OBJ_DQ;
                            state_d = S_RD1;
                        end
                    end else begin
                        n_d     = n_q + 7'd1;
                        state_d = (n_q == C_LAST_N) ? S_DONE : S_ADDR;
                    end
                end
                S_RD1: state_d = S_RD2;
                S_RD2: begin
                    code_d  = I_OBJ_DQ;
                    state_d = S_RD3;
                end
                S_RD3: begin
                    attr_d  = I_OBJ_DQ;
                    state_d = S_CAP;
                end
                S_CAP: begin
                    w_wr    = 1'b1;
                    n_d     = n_q + 7'd1;
                    state_d = (n_q == C_LAST_N) ? S_DONE : S_ADDR;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Byte offset within the entry; a re-issue points at the previous byte.
    always_comb begin
        w_sub = 2'd0;
        if (w_reissue) begin
            case (state_q)
                S_RD2:   w_sub = 2'd1;
                S_RD3:   w_sub = 2'd2;
                S_CAP:   w_sub = 2'd3;
                default: w_sub = 2'd0;
            endcase
        end else begin
            case (state_q)
                S_RD1:   w_sub = 2'd1;
                S_RD2:   w_sub = 2'd2;
                S_RD3:   w_sub = 2'd3;
                S_CAP:   w_sub = 2'd3;
                default: w_sub = 2'd0;
            endcase
        end
    end

    assign O_OBJ_AB    = {1'b0, n_q, w_sub};
    assign O_OBJ_RD    = (w_addr_state & ~w_busy_gate) | w_reissue;
    assign O_SCAN_DONE = (state_q == S_DONE);

    assign O_LIST_Y    = bank_q[w_disp][I_LIST_IDX][31:24];
    assign O_LIST_CODE = bank_q[w_disp][I_LIST_IDX][23:16];
    assign O_LIST_ATTR = bank_q[w_disp][I_LIST_IDX][15:8];
    assign O_LIST_X    = bank_q[w_disp][I_LIST_IDX][7:0];
    assign O_LIST_CNT  = cnt_q[w_disp];
    assign O_OVERFLOW  = ovf_q[w_disp];

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q  <= S_IDLE;
            n_q      <= 7'd0;
            vline_q  <= 8'd0;
            y_q      <= 8'd0;
            code_q   <= 8'd0;
            attr_q   <= 8'd0;
            sel_q    <= 1'b0;
            cnt_q[0] <= 5'd0;
            cnt_q[1] <= 5'd0;
            ovf_q    <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < 16; e++) begin
                    bank_q[b][e] <= 32'd0;
                end
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            vline_q <= vline_d;
            y_q     <= y_d;
            code_q  <= code_d;
            attr_q  <= attr_d;
            sel_q   <= sel_d;
            // The bank about to be scanned into is the old display bank.
            if (w_swap) begin
                cnt_q[w_disp] <= 5'd0;
                ovf_q[w_disp] <= 1'b0;
            end
            if (w_wr) begin
                bank_q[w_scan][cnt_q[w_scan][3:0]] <= {y_q, code_q, attr_q, I_OBJ_DQ};
                cnt_q[w_scan] <= cnt_q[w_scan] + 5'd1;
            end
            if (w_ovf_set) begin
                ovf_q[w_scan] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dkong3_obj_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_dkong3_obj_scan
// Purpose  : Self-checking bench for dkong3_obj_scan: table of single-entry
//            scans plus hand sequences for overflow, abort, reset and DMA.
// Revision : 1.0  initial release
// ============================================================================
module tb_dkong3_obj_scan;

    logic       clk;
    logic       rst_n;
    logic       h_start;
    logic [7:0] vpos;
    logic       dma_busy;
    logic [7:0] dq;
    logic [9:0] ab;
    logic       rd;
    logic [3:0] idx;
    logic [7:0] ly, lcode, lattr, lx;
    logic [4:0] lcnt;
    logic       done;
    logic       ovf;

    logic [7:0] mem [0:1023];

    int total = 0;
    int bad   = 0;

    dkong3_obj_scan dut (
        .I_CLK      (clk),
        .I_RSTn     (rst_n),
        .I_H_START  (h_start),
        .I_VPOS     (vpos),
        .I_DMA_BUSY (dma_busy),
        .I_OBJ_DQ   (dq),
        .O_OBJ_AB   (ab),
        .O_OBJ_RD   (rd),
        .I_LIST_IDX (idx),
        .O_LIST_Y   (ly),
        .O_LIST_CODE(lcode),
        .O_LIST_ATTR(lattr),
        .O_LIST_X   (lx),
        .O_LIST_CNT (lcnt),
        .O_SCAN_DONE(done),
        .O_OVERFLOW (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous object RAM: data one cycle after the address.
    always @(posedge clk) dq <= mem[ab];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    endtask

    task automatic set_entry(input int n, input logic [7:0] y, c, a, x);
        mem[4*n]   = y;
        mem[4*n+1] = c;
        mem[4*n+2] = a;
        mem[4*n+3] = x;
    endtask

    // Returns at the negedge of the first ADDR cycle.
    task automatic pulse_start(input logic [7:0] v);
        @(negedge clk);
        vpos    = v;
        h_start = 1'b1;
        @(negedge clk);
        h_start = 1'b0;
    endtask

    // Counts cycles from the first ADDR cycle to O_SCAN_DONE (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic entry_at(input logic [3:0] i, output logic [31:0] e);
        idx = i;
        #1;
        e = {ly, lcode, lattr, lx};
    endtask

    typedef struct {
        logic [7:0] y, code, attr, x, vpos;
        logic [4:0] cnt;
        int         cyc;
    } vec_t;

    vec_t       vt [7];
    int         cyc;
    logic [31:0] e;

    initial begin
        vt[0] = '{8'h40, 8'h12, 8'h03, 8'h80, 8'h4F, 5'd1, 196};
        vt[1] = '{8'h40, 8'h12, 8'h03, 8'h80, 8'h50, 5'd0, 192};
        vt[2] = '{8'h40, 8'h21, 8'h30, 8'h08, 8'h40, 5'd1, 196};
        vt[3] = '{8'hF8, 8'hAA, 8'h55, 8'h11, 8'h05, 5'd1, 196};
        vt[4] = '{8'hF8, 8'hAA, 8'h55, 8'h11, 8'h08, 5'd0, 192};
        vt[5] = '{8'h00, 8'h77, 8'h66, 8'h55, 8'h00, 5'd0, 192};
        vt[6] = '{8'h40, 8'h12, 8'h03, 8'h80, 8'h3F, 5'd0, 192};

        rst_n = 1'b0; h_start = 1'b0; vpos = 8'h00; dma_busy = 1'b0; idx = 4'd0;
        clear_mem();
        repeat (3) @(negedge clk);
        check("reset_ab", 32'(ab), 32'h0);
        check("reset_rd", 32'(rd), 32'h0);
        check("reset_cnt", 32'(lcnt), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_ovf", 32'(ovf), 32'h0);
        check("reset_entry", {ly, lcode, lattr, lx}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_rd", 32'(rd), 32'h0);

        // Table: one candidate in entry 0, others empty.
        for (int i = 0; i < 7; i++) begin
            clear_mem();
            set_entry(0, vt[i].y, vt[i].code, vt[i].attr, vt[i].x);
            pulse_start(vt[i].vpos);
            check($sformatf("v%0d_first_addr", i), {22'd0, rd, ab[9:0] == 10'd0}, 32'h3);
            wait_done(cyc);
            check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vt[i].cyc));
            pulse_start(8'h00);
            check($sformatf("v%0d_cnt", i), 32'(lcnt), 32'(vt[i].cnt));
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'h0);
            check($sformatf("v%0d_done_clr", i), 32'(done), 32'h0);
            if (vt[i].cnt == 5'd1) begin
                entry_at(4'd0, e);
                check($sformatf("v%0d_entry0", i), e,
                      {vt[i].y, vt[i].code, vt[i].attr, vt[i].x});
            end
        end

        // Overflow: 20 hits, list keeps the first 16 and the scan ends early.
        clear_mem();
        for (int n = 0; n < 20; n++) set_entry(n, 8'h20, 8'(n), 8'(n + 8'h40), 8'(n + 8'h80));
        pulse_start(8'h20);
        wait_done(cyc);
        check("ovf_cycles", 32'(cyc), 32'd98);
        pulse_start(8'h00);
        check("ovf_cnt", 32'(lcnt), 32'd16);
        check("ovf_flag", 32'(ovf), 32'h1);
        for (int n = 0; n < 16; n++) begin
            entry_at(4'(n), e);
            check($sformatf("ovf_entry%0d", n), e, {8'h20, 8'(n), 8'(n + 8'h40), 8'(n + 8'h80)});
        end

        // Reset during RD2 of a hit: everything back to zero at once.
        clear_mem();
        set_entry(0, 8'h40, 8'h12, 8'h03, 8'h80);
        pulse_start(8'h40);
        repeat (3) @(negedge clk);
        check("rd2_ab", 32'(ab), 32'h2);
        check("rd2_rd", 32'(rd), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_ab", 32'(ab), 32'h0);
        check("arst_rd", 32'(rd), 32'h0);
        check("arst_cnt", 32'(lcnt), 32'h0);
        check("arst_ovf", 32'(ovf), 32'h0);
        idx = 4'd3;
        #1;
        check("arst_entry", {ly, lcode, lattr, lx}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_idle_rd", 32'(rd), 32'h0);
        check("arst_idle_done", 32'(done), 32'h0);

        // Abort 50 cycles into a 3-hit scan: third hit (CAP at 53) is lost.
        clear_mem();
        set_entry(0,  8'h60, 8'hA0, 8'hB0, 8'hC0);
        set_entry(10, 8'h60, 8'hA1, 8'hB1, 8'hC1);
        set_entry(20, 8'h60, 8'hA2, 8'hB2, 8'hC2);
        pulse_start(8'h60);
        repeat (50) @(negedge clk);
        h_start = 1'b1;
        vpos    = 8'h00;
        @(negedge clk);
        h_start = 1'b0;
        check("abort_cnt", 32'(lcnt), 32'd2);
        check("abort_ovf", 32'(ovf), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        entry_at(4'd1, e);
        check("abort_entry1", e, 32'h60A1B1C1);

        // DMA busy for 10 cycles at CHK of entry 5 (cycle 11); hit at entry 7.
        clear_mem();
        set_entry(7, 8'h30, 8'h5A, 8'hA5, 8'h3C);
        pulse_start(8'h30);
        repeat (11) @(negedge clk);
        dma_busy = 1'b1;
        @(negedge clk);
`ifdef DKONG3_OBJSCAN_DMA_HOLD_EN
        check("hold_rd", 32'(rd), 32'h0);
        check("hold_ab", 32'(ab), 32'h014);
`else
        check("nohold_rd", 32'(rd), 32'h1);
        check("nohold_ab", 32'(ab), 32'h018);
`endif
        repeat (9) @(negedge clk);
        dma_busy = 1'b0;
        cyc = 21;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
`ifdef DKONG3_OBJSCAN_DMA_HOLD_EN
        check("hold_cycles", 32'(cyc), 32'd207);
`else
        check("nohold_cycles", 32'(cyc), 32'd196);
`endif
        pulse_start(8'h00);
        check("dma_cnt", 32'(lcnt), 32'd1);
        entry_at(4'd0, e);
        check("dma_entry0", e, 32'h305AA53C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
